// File: rtl/eg2000_pkg.sv
// Shared types and constants for the EG2000 PS/2 keyboard matrix.
// Frame FSM states, matrix row indices, scancode constants and the keymap entry type.
package eg2000_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_t;

  localparam int ROW_SPECIAL = 6;
  localparam int ROW_SHIFT   = 7;

  localparam logic [7:0] PFX_RELEASE = 8'hF0;
  localparam logic [7:0] PFX_EXTEND  = 8'hE0;
  localparam logic [7:0] PFX_PAUSE   = 8'hE1;

  // Keyboard housekeeping replies; these must not disturb pending prefixes.
  localparam logic [7:0] SC_BAT_OK = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_RESEND = 8'hFE;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_F12    = 8'h07;

  typedef struct packed {
    logic       vld;
    logic [2:0] row;
    logic [2:0] col;
  } key_loc_t;

  function automatic key_loc_t key_at(input int r, input int c);
    key_at = '{vld: 1'b1, row: 3'(r), col: 3'(c)};
  endfunction

endpackage

// File: rtl/ps2_keymap.sv
// Scancode set 2 to EG2000 (TRS-80 layout) matrix position lookup.
// Purely combinational; unmapped codes return vld=0.
module ps2_keymap
  import eg2000_pkg::*;
(
  input  logic       ext,
  input  logic [7:0] code,
  output key_loc_t   loc
);

  always_comb begin
    loc = '0;
    case ({ext, code})
      9'h00E: loc = key_at(0, 0);  // backtick stands in for @
      9'h01C: loc = key_at(0, 1);
      9'h032: loc = key_at(0, 2);
      9'h021: loc = key_at(0, 3);
      9'h023: loc = key_at(0, 4);
      9'h024: loc = key_at(0, 5);
      9'h02B: loc = key_at(0, 6);
      9'h034: loc = key_at(0, 7);
      9'h033: loc = key_at(1, 0);
      9'h043: loc = key_at(1, 1);
      9'h03B: loc = key_at(1, 2);
      9'h042: loc = key_at(1, 3);
      9'h04B: loc = key_at(1, 4);
      9'h03A: loc = key_at(1, 5);
      9'h031: loc = key_at(1, 6);
      9'h044: loc = key_at(1, 7);
      9'h04D: loc = key_at(2, 0);
      9'h015: loc = key_at(2, 1);
      9'h02D: loc = key_at(2, 2);
      9'h01B: loc = key_at(2, 3);
      9'h02C: loc = key_at(2, 4);
      9'h03C: loc = key_at(2, 5);
      9'h02A: loc = key_at(2, 6);
      9'h01D: loc = key_at(2, 7);
      9'h022: loc = key_at(3, 0);
      9'h035: loc = key_at(3, 1);
      9'h01A: loc = key_at(3, 2);
      9'h045: loc = key_at(4, 0);
      9'h016: loc = key_at(4, 1);
      9'h01E: loc = key_at(4, 2);
      9'h026: loc = key_at(4, 3);
      9'h025: loc = key_at(4, 4);
      9'h02E: loc = key_at(4, 5);
      9'h036: loc = key_at(4, 6);
      9'h03D: loc = key_at(4, 7);
      9'h03E: loc = key_at(5, 0);
      9'h046: loc = key_at(5, 1);
      9'h052: loc = key_at(5, 2);  // apostrophe stands in for :
      9'h04C: loc = key_at(5, 3);
      9'h041: loc = key_at(5, 4);
      9'h04E: loc = key_at(5, 5);
      9'h049: loc = key_at(5, 6);
      9'h04A: loc = key_at(5, 7);
      9'h05A: loc = key_at(ROW_SPECIAL, 0);
      9'h15A: loc = key_at(ROW_SPECIAL, 0);
      9'h066: loc = key_at(ROW_SPECIAL, 1);
      9'h076: loc = key_at(ROW_SPECIAL, 2);
      9'h175: loc = key_at(ROW_SPECIAL, 3);
      9'h172: loc = key_at(ROW_SPECIAL, 4);
      9'h16B: loc = key_at(ROW_SPECIAL, 5);
      9'h174: loc = key_at(ROW_SPECIAL, 6);
      9'h029: loc = key_at(ROW_SPECIAL, 7);
      default: loc = '0;
    endcase
  end

endmodule

// File: rtl/ps2_matrix.sv
// PS/2 keyboard receiver and decoder feeding the EG2000 8x8 key matrix; F12 exported as boot.
// Matrix read is zero latency from addr; strobe/decode one cycle after the stop edge; no backpressure.
module ps2_matrix
  import eg2000_pkg::*;
#(
  parameter int FILTER  = 4,
  parameter int TIMEOUT = 35468
) (
  input  logic       clock,
  input  logic       power,
  input  logic [1:0] ps2,
  input  logic [7:0] addr,
  output logic [7:0] data,
  output logic       boot,
  output logic       strobe
);

  localparam int FW = $clog2(FILTER + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]    sync0, sync1;
  logic [FW-1:0] filt_cnt;
  logic          filt_clk;
  logic          fall;
  logic          fall_dat;

  frame_state_t  state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par;
  logic [TW-1:0] tmo;
  logic [7:0]    code;

  logic          rel_flag, ext_flag;
  logic [2:0]    skip;
  logic          lshift, rshift;
  logic [6:0][7:0] matrix;
  key_loc_t      loc;

  // Lines idle high, so the synchroniser resets to 1 to avoid a phantom edge.
  always_ff @(posedge clock or negedge power) begin
    if (!power) begin
      sync0 <= 2'b11;
      sync1 <= 2'b11;
    end else begin
      sync0 <= ps2;
      sync1 <= sync0;
    end
  end

  always_ff @(posedge clock or negedge power) begin
    if (!power) begin
      filt_cnt <= '0;
      filt_clk <= 1'b1;
      fall     <= 1'b0;
      fall_dat <= 1'b0;
    end else begin
      fall     <= 1'b0;
      fall_dat <= sync1[1];
      if (sync1[0] == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER - 1)) begin
        filt_clk <= sync1[0];
        filt_cnt <= '0;
        fall     <= filt_clk;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge power) begin
    if (!power) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      tmo     <= '0;
      code    <= '0;
      strobe  <= 1'b0;
    end else begin
      strobe <= 1'b0;
      if (fall || state == ST_IDLE) tmo <= '0;
      else                          tmo <= tmo + 1'b1;

      if (fall) begin
        case (state)
          ST_IDLE: begin
            if (!fall_dat) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            shreg   <= {fall_dat, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
            par   <= fall_dat;
            state <= ST_STOP;
          end
          ST_STOP: begin
            state <= ST_IDLE;
            if (fall_dat && (^{shreg, par})) begin
              strobe <= 1'b1;
              code   <= shreg;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end else if (state != ST_IDLE && tmo == TW'(TIMEOUT - 1)) begin
        state <= ST_IDLE;
      end
    end
  end

  ps2_keymap u_keymap (
    .ext  (ext_flag),
    .code (code),
    .loc  (loc)
  );

  always_ff @(posedge clock or negedge power) begin
    if (!power) begin
      matrix   <= '0;
      rel_flag <= 1'b0;
      ext_flag <= 1'b0;
      skip     <= '0;
      lshift   <= 1'b0;
      rshift   <= 1'b0;
      boot     <= 1'b0;
    end else if (strobe) begin
      if (skip != 3'd0) begin
        skip <= skip - 1'b1;
      end else begin
        case (code)
          PFX_PAUSE:   skip     <= 3'd7;
          PFX_RELEASE: rel_flag <= 1'b1;
          PFX_EXTEND:  ext_flag <= 1'b1;
          SC_BAT_OK, SC_ACK, SC_ECHO, SC_RESEND: ;
          default: begin
            if (!ext_flag && code == SC_LSHIFT)      lshift <= ~rel_flag;
            else if (!ext_flag && code == SC_RSHIFT) rshift <= ~rel_flag;
            else if (!ext_flag && code == SC_F12)    boot   <= ~rel_flag;
            else begin
              for (int r = 0; r < 7; r++)
                for (int c = 0; c < 8; c++)
                  if (loc.vld && loc.row == 3'(r) && loc.col == 3'(c))
                    matrix[r][c] <= ~rel_flag;
            end
            rel_flag <= 1'b0;
            ext_flag <= 1'b0;
          end
        endcase
      end
    end
  end

  always_comb begin
    data = '0;
    for (int r = 0; r < 7; r++)
      if (addr[r]) data = data | matrix[r];
    if (addr[ROW_SHIFT]) data[0] = data[0] | lshift | rshift;
  end

endmodule

// File: tb/tb_ps2_matrix.sv
// Directed bench for ps2_matrix: PS/2 frames driven bit by bit, matrix read back through addr.
module tb_ps2_matrix;

  localparam int TIMEOUT = 35468;

  logic       clock = 1'b0;
  logic       power = 1'b0;
  logic [1:0] ps2   = 2'b11;
  logic [7:0] addr  = 8'h00;
  logic [7:0] data;
  logic       boot;
  logic       strobe;

  int checks  = 0;
  int errors  = 0;
  int strobes = 0;
  int exp_strobes = 0;

  ps2_matrix dut (
    .clock  (clock),
    .power  (power),
    .ps2    (ps2),
    .addr   (addr),
    .data   (data),
    .boot   (boot),
    .strobe (strobe)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (strobe) strobes++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2[1] = bits[i];
      wait_clk(10);
      ps2[0] = 1'b0;
      wait_clk(20);
      ps2[0] = 1'b1;
      wait_clk(10);
    end
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b, input logic bad);
    frame = {1'b1, (~^b) ^ bad, b, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic bad);
    send_bits(frame(b, bad), 11);
    ps2[1] = 1'b1;
    wait_clk(20);
    if (!bad) exp_strobes++;
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0);
  endtask

  task automatic read_row(input string tag, input logic [7:0] a, input logic [7:0] exp);
    addr = a;
    #1;
    check(tag, {24'd0, data}, {24'd0, exp});
  endtask

  initial begin
    wait_clk(3);
    read_row("reset_data", 8'hFF, 8'h00);
    check("reset_boot", {31'd0, boot}, 32'd0);
    check("reset_strobe", {31'd0, strobe}, 32'd0);
    @(negedge clock);
    power = 1'b1;
    wait_clk(10);
    read_row("idle_data", 8'hFF, 8'h00);

    // make then break of A
    send(8'h1C);
    check("a_make_strobe", strobes, exp_strobes);
    read_row("a_make", 8'h01, 8'h02);
    read_row("a_addr0", 8'h00, 8'h00);
    read_row("a_other_row", 8'h02, 8'h00);
    send(8'hF0);
    send(8'h1C);
    read_row("a_break", 8'h01, 8'h00);
    check("a_break_strobe", strobes, exp_strobes);

    // even parity is rejected silently
    send_frame(8'h1C, 1'b1);
    check("bad_par_strobe", strobes, exp_strobes);
    read_row("bad_par_data", 8'hFF, 8'h00);

    // two independent shift flops share row7 bit0
    send(8'h12);
    send(8'h59);
    read_row("shift_both", 8'h80, 8'h01);
    send(8'hF0);
    send(8'h12);
    read_row("shift_r_only", 8'h80, 8'h01);
    send(8'hF0);
    send(8'h59);
    read_row("shift_none", 8'h80, 8'h00);

    // extended UP versus bare keypad 8
    send(8'hE0);
    send(8'h75);
    read_row("up_make", 8'h40, 8'h08);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    read_row("up_break", 8'h40, 8'h00);
    send(8'h75);
    read_row("kp8_row6", 8'h40, 8'h00);
    read_row("kp8_all", 8'hFF, 8'h00);

    // partial frame abandoned by timeout
    send_bits(frame(8'h55, 1'b0), 5);
    ps2[1] = 1'b1;
    wait_clk(TIMEOUT + 1);
    send(8'h5A);
    check("timeout_strobe", strobes, exp_strobes);
    read_row("timeout_enter", 8'h40, 8'h01);
    send(8'hF0);
    send(8'h5A);
    read_row("enter_break", 8'h40, 8'h00);

    // Pause sequence is swallowed whole
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    read_row("pause_quiet", 8'hFF, 8'h00);
    send(8'h1C);
    read_row("after_pause", 8'h01, 8'h02);

    // housekeeping byte between F0 and its code keeps the release flag
    send(8'hF0);
    send(8'hAA);
    send(8'h1C);
    read_row("aa_keeps_rel", 8'h01, 8'h00);
    check("aa_strobes", strobes, exp_strobes);

    // F12 boot, then reset in the middle of a frame
    send(8'h07);
    check("f12_boot", {31'd0, boot}, 32'd1);
    read_row("f12_not_matrix", 8'h3F, 8'h00);
    send(8'h29);
    read_row("space_make", 8'h40, 8'h80);
    send_bits(frame(8'h1C, 1'b0), 4);
    power = 1'b0;
    #1;
    check("rst_boot", {31'd0, boot}, 32'd0);
    read_row("rst_data", 8'hFF, 8'h00);
    ps2 = 2'b11;
    wait_clk(3);
    power = 1'b1;
    wait_clk(10);
    send(8'h29);
    read_row("post_rst_space", 8'h40, 8'h80);
    read_row("post_rst_all", 8'hFF, 8'h80);
    check("post_rst_boot", {31'd0, boot}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
